uart_cfg: RTL and testbench

UART_CFG -- requirements
Module: uart_cfg

---
 rtl/uart_cfg.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// uart_cfg -- parameterised UART: one transmitter and one receiver with an RX FIFO.
//
// Ports:
//   clk, reset        single rising-edge clock, asynchronous active-high reset
//   rx / tx           serial in (asynchronous, synchronised here) / serial out (idle high)
//   tx_valid/tx_ready/tx_data
//                     word handshake; tx_data is latched on accept
//   rx_valid/rx_ready/rx_data/rx_frame_err/rx_parity_err
//                     first-word fall-through FIFO head; pop on rx_valid && rx_ready
//   rx_overrun        sticky flag: a frame was dropped because the FIFO was full
//   rx_overrun_clr    clears rx_overrun (a simultaneous new overrun wins)
module uart_cfg #(
    parameter int CLK_FREQ  = 12000000,
    parameter int UART_FREQ = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int RX_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 rx_overrun_clr
);
    localparam int BIT_CLK = (UART_FREQ > 0) ? (CLK_FREQ + UART_FREQ - 1) / UART_FREQ : 0;
    localparam int CNT_W   = $clog2(STOP_BITS * BIT_CLK + 2);
    localparam int AW      = $clog2(RX_DEPTH);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLK - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * BIT_CLK - 1);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(BIT_CLK / 2);
    localparam logic [CNT_W-1:0] MID_M1    = CNT_W'(BIT_CLK - 1);
    localparam logic [CNT_W-1:0] MID       = CNT_W'(BIT_CLK);
    localparam logic [CNT_W-1:0] MID_P1    = CNT_W'(BIT_CLK + 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);
    localparam logic             PAR_EN    = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 1);

    generate
        if (BIT_CLK < 8) begin : g_bad_bitclk
            $error("uart_cfg: CLK_FREQ/UART_FREQ gives fewer than 8 clocks per bit");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
            $error("uart_cfg: DATA_BITS must be 5..8");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_cfg: STOP_BITS must be 1 or 2");
        end
        if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_cfg: RX_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    // ---------------------------------------------------------------- TX
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    tx <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        tx_shift <= tx_data;
                        tx_par   <= (^tx_data) ^ PAR_ODD;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_cnt   <= '0;
                        tx_state <= TX_START;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                TX_START, TX_DATA, TX_PAR: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_state == TX_DATA && tx_bit == IDX_LAST || tx_state == TX_PAR) begin
                            // last data bit done: parity next only when enabled
                            if (tx_state == TX_DATA && PAR_EN) begin
                                tx       <= tx_par;
                                tx_state <= TX_PAR;
                            end else begin
                                tx       <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            // START or a non-final data bit: shift out the next LSB
                            tx_bit   <= (tx_state == TX_START) ? 3'd0 : tx_bit + 3'd1;
                            tx       <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_state <= TX_DATA;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == STOP_LAST) begin
                        tx_ready <= 1'b1;
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- RX
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;
    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic                 ferr;
        logic                 perr;
    } rx_entry_t;

    rx_state_t            rx_state;
    logic                 rx_s1, rx_s2;
    logic [CNT_W-1:0]     rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_sa, rx_sb, rx_perr, rx_maj;
    logic                 push;
    rx_entry_t            push_entry;

    assign rx_maj = (rx_sa & rx_sb) | (rx_sa & rx_s2) | (rx_sb & rx_s2);

    // rx_cnt counts clocks since the middle of the previous bit, so every
    // data/parity/stop bit is sampled at the same offsets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_sa      <= 1'b1;
            rx_sb      <= 1'b1;
            rx_perr    <= 1'b0;
            push       <= 1'b0;
            push_entry <= '0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            push  <= 1'b0;
            case (rx_state)
                RX_IDLE: if (!rx_s2) begin
                    rx_cnt   <= CNT_ONE;
                    rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF) begin
                        // line back high at mid start bit: treat as a glitch
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_cnt   <= CNT_ONE;
                        rx_bit   <= '0;
                        rx_perr  <= 1'b0;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA, RX_PAR, RX_STOP: begin
                    rx_cnt <= rx_cnt + CNT_ONE;
                    if (rx_cnt == MID_M1) rx_sa <= rx_s2;
                    if (rx_cnt == MID)    rx_sb <= rx_s2;
                    if (rx_cnt == MID_P1) begin
                        rx_cnt <= CNT_TWO;
                        if (rx_state == RX_DATA) begin
                            rx_shift <= {rx_maj, rx_shift[DATA_BITS-1:1]};
                            rx_bit   <= rx_bit + 3'd1;
                            if (rx_bit == IDX_LAST) rx_state <= PAR_EN ? RX_PAR : RX_STOP;
                        end else if (rx_state == RX_PAR) begin
                            rx_perr  <= rx_maj ^ (^rx_shift) ^ PAR_ODD;
                            rx_state <= RX_STOP;
                        end else begin
                            push            <= 1'b1;
                            push_entry.data <= rx_shift;
                            push_entry.ferr <= ~rx_maj;
                            push_entry.perr <= rx_perr;
                            rx_state        <= rx_maj ? RX_IDLE : RX_BREAK;
                        end
                    end
                end
                RX_BREAK: if (rx_s2) rx_state <= RX_IDLE;
                default:  rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    rx_entry_t   mem [RX_DEPTH];
    rx_entry_t   head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, pop, wr_en;

    assign rx_valid      = (wr_ptr != rd_ptr);
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop           = rx_valid && rx_ready;
    // when full, a same-cycle pop frees the slot the push overwrites
    assign wr_en         = push && (!full || pop);
    assign head          = mem[rd_ptr[AW-1:0]];
    assign rx_data       = rx_valid ? head.data : '0;
    assign rx_frame_err  = rx_valid & head.ferr;
    assign rx_parity_err = rx_valid & head.perr;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            if (push && full && !pop) rx_overrun <= 1'b1;
            else if (rx_overrun_clr)  rx_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_cfg.sv
module tb_uart_cfg;
    localparam int BIT = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // 8N1 instance
    logic       rx_n = 1'b1, tx_n, tx_valid_n = 1'b0, tx_ready_n;
    logic [7:0] tx_data_n = '0, rx_data_n;
    logic       rx_valid_n, rx_ready_n = 1'b0, rx_fe_n, rx_pe_n, rx_ovr_n, rx_clr_n = 1'b0;
    // 8E1 instance
    logic       rx_e = 1'b1, tx_e, tx_valid_e = 1'b0, tx_ready_e;
    logic [7:0] tx_data_e = '0, rx_data_e;
    logic       rx_valid_e, rx_ready_e = 1'b0, rx_fe_e, rx_pe_e, rx_ovr_e, rx_clr_e = 1'b0;

    uart_cfg #(.CLK_FREQ(12000000), .UART_FREQ(1000000), .DATA_BITS(8), .PARITY(0),
               .STOP_BITS(1), .RX_DEPTH(4)) dut_n (
        .clk(clk), .reset(reset), .rx(rx_n), .tx(tx_n),
        .tx_valid(tx_valid_n), .tx_ready(tx_ready_n), .tx_data(tx_data_n),
        .rx_valid(rx_valid_n), .rx_ready(rx_ready_n), .rx_data(rx_data_n),
        .rx_frame_err(rx_fe_n), .rx_parity_err(rx_pe_n),
        .rx_overrun(rx_ovr_n), .rx_overrun_clr(rx_clr_n));

    uart_cfg #(.CLK_FREQ(12000000), .UART_FREQ(1000000), .DATA_BITS(8), .PARITY(2),
               .STOP_BITS(1), .RX_DEPTH(4)) dut_e (
        .clk(clk), .reset(reset), .rx(rx_e), .tx(tx_e),
        .tx_valid(tx_valid_e), .tx_ready(tx_ready_e), .tx_data(tx_data_e),
        .rx_valid(rx_valid_e), .rx_ready(rx_ready_e), .rx_data(rx_data_e),
        .rx_frame_err(rx_fe_e), .rx_parity_err(rx_pe_e),
        .rx_overrun(rx_ovr_e), .rx_overrun_clr(rx_clr_e));

    int n_chk  = 0;
    int n_fail = 0;

    // reference model: expected FIFO contents and sticky overrun per instance
    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } ent_t;
    ent_t q_n[$];
    ent_t q_e[$];
    logic ovr_n_m = 1'b0;
    logic ovr_e_m = 1'b0;

    // value of the serial line during bit slot idx of a frame
    function automatic logic frame_bit(input logic [7:0] w, input bit par, input bit flip,
                                       input logic stopv, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (par && idx == 9) return (^w) ^ flip;
        if (idx == (par ? 10 : 9)) return stopv;
        return 1'b1;
    endfunction

    task automatic model_push(input int sel, input logic [7:0] d, input logic fe, input logic pe);
        ent_t e;
        e.d = d; e.fe = fe; e.pe = pe;
        if (sel == 1) begin
            if (q_e.size() < 4) q_e.push_back(e); else ovr_e_m = 1'b1;
        end else begin
            if (q_n.size() < 4) q_n.push_back(e); else ovr_n_m = 1'b1;
        end
    endtask

    // drive one frame on rx; optional one-cycle glitch inside data bit gbit
    task automatic rx_frame(input int sel, input logic [7:0] w, input bit flip, input logic stopv,
                            input int gbit, input int gpos);
        int nb;
        logic v;
        nb = (sel == 1) ? 11 : 10;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < BIT; c++) begin
                v = frame_bit(w, sel == 1, flip, stopv, b);
                if (b == gbit && c == gpos) v = ~v;
                if (sel == 1) rx_e = v; else rx_n = v;
                @(negedge clk);
            end
        end
        rx_e = 1'b1; rx_n = 1'b1;
        repeat (4) @(negedge clk);
        model_push(sel, w, ~stopv, (sel == 1) ? logic'(flip) : 1'b0);
    endtask

    task automatic pop_check(input int sel, input string name);
        ent_t e;
        logic v, fe, pe;
        logic [7:0] d;
        if (sel == 1) begin
            e = q_e.pop_front(); v = rx_valid_e; d = rx_data_e; fe = rx_fe_e; pe = rx_pe_e;
        end else begin
            e = q_n.pop_front(); v = rx_valid_n; d = rx_data_n; fe = rx_fe_n; pe = rx_pe_n;
        end
        n_chk++;
        if (v !== 1'b1 || d !== e.d || fe !== e.fe || pe !== e.pe) begin
            n_fail++;
            $display("FAIL %s: got valid=%b data=%h fe=%b pe=%b, expected valid=1 data=%h fe=%b pe=%b",
                     name, v, d, fe, pe, e.d, e.fe, e.pe);
        end
        if (sel == 1) rx_ready_e = 1'b1; else rx_ready_n = 1'b1;
        @(negedge clk);
        rx_ready_e = 1'b0; rx_ready_n = 1'b0;
    endtask

    task automatic check_empty(input int sel, input string name);
        logic v;
        v = (sel == 1) ? rx_valid_e : rx_valid_n;
        n_chk++;
        if (v !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: rx_valid=%b, expected 0", name, v);
        end
    endtask

    task automatic check_ovr(input int sel, input string name);
        logic o, m;
        o = (sel == 1) ? rx_ovr_e : rx_ovr_n;
        m = (sel == 1) ? ovr_e_m : ovr_n_m;
        n_chk++;
        if (o !== m) begin
            n_fail++;
            $display("FAIL %s: rx_overrun=%b, expected %b", name, o, m);
        end
    endtask

    // send a word and check every cycle of the serial frame plus tx_ready
    task automatic send_check(input int sel, input logic [7:0] w, input string name);
        int t, nb, bad_tx, bad_rdy;
        logic rdy, line;
        nb = (sel == 1) ? 11 : 10;
        t = 0;
        while (((sel == 1) ? tx_ready_e : tx_ready_n) !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (t >= 300) begin
            n_fail++;
            $display("FAIL %s: tx_ready=0 after %0d cycles, expected 1", name, t);
            return;
        end
        if (sel == 1) begin tx_valid_e = 1'b1; tx_data_e = w; end
        else          begin tx_valid_n = 1'b1; tx_data_n = w; end
        @(negedge clk);
        tx_valid_e = 1'b0; tx_valid_n = 1'b0;
        tx_data_e = 8'($urandom_range(255)); tx_data_n = 8'($urandom_range(255));
        bad_tx = 0; bad_rdy = 0;
        for (int k = 0; k < nb * BIT; k++) begin
            line = (sel == 1) ? tx_e : tx_n;
            rdy  = (sel == 1) ? tx_ready_e : tx_ready_n;
            if (line !== frame_bit(w, sel == 1, 1'b0, 1'b1, k / BIT)) bad_tx++;
            if (rdy !== 1'b0) bad_rdy++;
            @(negedge clk);
        end
        line = (sel == 1) ? tx_e : tx_n;
        rdy  = (sel == 1) ? tx_ready_e : tx_ready_n;
        if (line !== 1'b1) bad_tx++;
        n_chk++;
        if (bad_tx != 0) begin
            n_fail++;
            $display("FAIL %s tx line: %0d wrong cycles for word %h, expected 0", name, bad_tx, w);
        end
        n_chk++;
        if (bad_rdy != 0 || rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s tx_ready: %0d early-high cycles, final=%b, expected 0 and 1",
                     name, bad_rdy, rdy);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_chk++;
        if ({tx_n, tx_ready_n, rx_valid_n, rx_data_n, rx_fe_n, rx_pe_n, rx_ovr_n} !== 14'b10_0000_0000_0000 ||
            {tx_e, tx_ready_e, rx_valid_e, rx_data_e, rx_fe_e, rx_pe_e, rx_ovr_e} !== 14'b10_0000_0000_0000) begin
            n_fail++;
            $display("FAIL reset_values: n=%b e=%b, expected 10000000000000",
                     {tx_n, tx_ready_n, rx_valid_n, rx_data_n, rx_fe_n, rx_pe_n, rx_ovr_n},
                     {tx_e, tx_ready_e, rx_valid_e, rx_data_e, rx_fe_e, rx_pe_e, rx_ovr_e});
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (tx_ready_n !== 1'b1 || tx_ready_e !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b%b, expected 11", tx_ready_n, tx_ready_e);
        end
    endtask

    task automatic test_tx_a5;
        send_check(0, 8'hA5, "tx_a5_8n1");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) send_check(0, 8'($urandom_range(255)), "tx_b2b_8n1");
        for (int i = 0; i < 3; i++) send_check(1, 8'($urandom_range(255)), "tx_b2b_8e1");
        send_check(1, 8'h00, "tx_zero_8e1");
    endtask

    task automatic test_rx_parity;
        rx_frame(1, 8'h3C, 1'b0, 1'b1, -1, 0);
        pop_check(1, "rx_3c_parity_ok");
        rx_frame(1, 8'h3C, 1'b1, 1'b1, -1, 0);
        pop_check(1, "rx_3c_parity_bad");
        check_empty(1, "rx_parity_drained");
    endtask

    task automatic test_glitch;
        rx_n = 1'b0;
        repeat (4) @(negedge clk);
        rx_n = 1'b1;
        repeat (40) @(negedge clk);
        check_empty(0, "rx_glitch_reject");
    endtask

    task automatic test_rx_random;
        int sel, gbit;
        bit flip;
        logic stopv;
        logic [7:0] w;
        for (int i = 0; i < 12; i++) begin
            sel   = i % 2;
            w     = 8'($urandom_range(255));
            flip  = (sel == 1) ? bit'($urandom_range(1)) : 1'b0;
            stopv = ($urandom_range(7) != 0);
            gbit  = ($urandom_range(1) == 1) ? int'($urandom_range(8, 1)) : -1;
            rx_frame(sel, w, flip, stopv, gbit, int'($urandom_range(BIT - 1)));
            pop_check(sel, "rx_random");
        end
        check_empty(0, "rx_random_drained_n");
        check_empty(1, "rx_random_drained_e");
    endtask

    task automatic test_overrun;
        for (int i = 1; i <= 5; i++) rx_frame(0, 8'(i), 1'b0, 1'b1, -1, 0);
        check_ovr(0, "overrun_set");
        for (int i = 0; i < 4; i++) pop_check(0, "overrun_order");
        check_empty(0, "overrun_frame5_lost");
        check_ovr(0, "overrun_sticky");
        rx_clr_n = 1'b1;
        @(negedge clk);
        rx_clr_n = 1'b0;
        ovr_n_m = 1'b0;
        check_ovr(0, "overrun_cleared");
    endtask

    task automatic test_break;
        rx_n = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        rx_n = 1'b1;
        repeat (30) @(negedge clk);
        model_push(0, 8'h00, 1'b1, 1'b0);
        pop_check(0, "break_entry");
        check_empty(0, "break_single_entry");
        rx_frame(0, 8'h55, 1'b0, 1'b1, -1, 0);
        pop_check(0, "after_break_55");
    endtask

    task automatic test_reset_mid_frame;
        int t;
        t = 0;
        while (tx_ready_n !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        tx_valid_n = 1'b1; tx_data_n = 8'hFF;
        @(negedge clk);
        tx_valid_n = 1'b0;
        // partial RX frame on the parity instance while TX is busy
        rx_e = 1'b0;
        repeat (40) @(negedge clk);
        reset = 1'b1;
        #1;
        n_chk++;
        if (tx_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_tx_async: tx=%b, expected 1", tx_n);
        end
        rx_e = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (tx_n !== 1'b1 || tx_ready_n !== 1'b0 || rx_valid_e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: tx=%b tx_ready=%b rx_valid_e=%b, expected 1 0 0",
                     tx_n, tx_ready_n, rx_valid_e);
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (tx_ready_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release_ready: tx_ready=%b, expected 1", tx_ready_n);
        end
        repeat (300) @(negedge clk);
        check_empty(1, "reset_mid_rx_no_push");
        send_check(0, 8'hFF, "tx_after_reset_ff");
    endtask

    initial begin
        test_reset;
        test_tx_a5;
        test_back_to_back;
        test_rx_parity;
        test_glitch;
        test_rx_random;
        test_overrun;
        test_break;
        test_reset_mid_frame;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
